// File: rtl/cpu_pkg.sv
// Shared defaults and types for the issue-side pipeline blocks.
// Holds the datapath sizing and the output-stage state encoding.
package cpu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREGS_DEF = 4;
    localparam int OPW_DEF   = 8;
    localparam int CNTW_DEF  = 16;
    localparam int REG_ZERO  = 0;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register pending bits for in-flight destinations.
// Lookups already discount a writeback retiring in the same cycle.
module scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [IW-1:0] clr_idx,
    input  logic [IW-1:0] q1_idx,
    input  logic [IW-1:0] q2_idx,
    input  logic [IW-1:0] q3_idx,
    output logic          q1_pend,
    output logic          q2_pend,
    output logic          q3_pend
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] pend_now;

    always_comb begin
        pend_now = pending_q;
        if (clr_en) begin
            pend_now[clr_idx] = 1'b0;
        end
        pend_now[REG_ZERO] = 1'b0;
    end

    assign q1_pend = pend_now[q1_idx];
    assign q2_pend = pend_now[q2_idx];
    assign q3_pend = pend_now[q3_idx];

    // Clear first, then set, so a new claim on the retiring register survives.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != IW'(REG_ZERO))) begin
            pending_d[set_idx] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, forwards same-cycle writeback,
// stalls on pending hazards and presents a one-deep operand bundle downstream.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = $clog2(WIDTH),
    parameter int NREGS      = NREGS_DEF,
    parameter int OPW        = OPW_DEF,
    parameter int CNTW       = CNTW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_we,
    input  logic [OPW-1:0]        in_op,
    output logic [ADDR_WIDTH-1:0] rf_rnum1,
    output logic [ADDR_WIDTH-1:0] rf_rnum2,
    input  logic [WIDTH-1:0]      rf_rdata1,
    input  logic [WIDTH-1:0]      rf_rdata2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_a,
    output logic [WIDTH-1:0]      out_b,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_rd_we,
    output logic [OPW-1:0]        out_op,
    output logic [CNTW-1:0]       stall_cnt
);

    localparam int IW = $clog2(NREGS);

    logic [IW-1:0] rs1_idx;
    logic [IW-1:0] rs2_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wb_idx;
    logic          unused_wb_hi;

    logic          rs1_pend;
    logic          rs2_pend;
    logic          rd_pend;
    logic          hazard;
    logic          accept;
    logic          sb_set;

    out_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [ADDR_WIDTH-1:0] out_rd_q, out_rd_d;
    logic             out_rd_we_q, out_rd_we_d;
    logic [OPW-1:0]   out_op_q, out_op_d;
    logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;

    assign rs1_idx = in_rs1[IW-1:0];
    assign rs2_idx = in_rs2[IW-1:0];
    assign rd_idx  = in_rd[IW-1:0];
    assign wb_idx  = wb_rd[IW-1:0];
    assign unused_wb_hi = ^wb_rd;

    assign rf_rnum1 = in_rs1;
    assign rf_rnum2 = in_rs2;

    scoreboard #(
        .NREGS (NREGS),
        .IW    (IW)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (sb_set),
        .set_idx (rd_idx),
        .clr_en  (wb_valid),
        .clr_idx (wb_idx),
        .q1_idx  (rs1_idx),
        .q2_idx  (rs2_idx),
        .q3_idx  (rd_idx),
        .q1_pend (rs1_pend),
        .q2_pend (rs2_pend),
        .q3_pend (rd_pend)
    );

    always_comb begin
        hazard = 1'b0;
        if ((rs1_idx != IW'(REG_ZERO)) && rs1_pend) begin
            hazard = 1'b1;
        end
        if ((rs2_idx != IW'(REG_ZERO)) && rs2_pend) begin
            hazard = 1'b1;
        end
        if (in_rd_we && (rd_idx != IW'(REG_ZERO)) && rd_pend) begin
            hazard = 1'b1;
        end
    end

    assign out_valid = (state_q == OUT_FULL);
    assign in_ready  = (!out_valid || out_ready) && !hazard;
    assign accept    = in_valid && in_ready;
    assign sb_set    = accept && in_rd_we && (rd_idx != IW'(REG_ZERO));

    // The register file still shows the old value in its write cycle, so the
    // writeback bus takes priority over the read data.
    always_comb begin
        opnd_a = rf_rdata1;
        if (rs1_idx == IW'(REG_ZERO)) begin
            opnd_a = '0;
        end else if (wb_valid && (wb_idx == rs1_idx)) begin
            opnd_a = wb_data;
        end

        opnd_b = rf_rdata2;
        if (rs2_idx == IW'(REG_ZERO)) begin
            opnd_b = '0;
        end else if (wb_valid && (wb_idx == rs2_idx)) begin
            opnd_b = wb_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_rd_d    = out_rd_q;
        out_rd_we_d = out_rd_we_q;
        out_op_d    = out_op_q;

        case (state_q)
            OUT_EMPTY: begin
                if (accept) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_ready && !accept) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase

        if (accept) begin
            out_a_d     = opnd_a;
            out_b_d     = opnd_b;
            out_rd_d    = in_rd;
            out_rd_we_d = in_rd_we;
            out_op_d    = in_op;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && hazard && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= OUT_EMPTY;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
            out_rd_we_q <= 1'b0;
            out_op_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_rd_q    <= out_rd_d;
            out_rd_we_q <= out_rd_we_d;
            out_op_q    <= out_op_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_rd    = out_rd_q;
    assign out_rd_we = out_rd_we_q;
    assign out_op    = out_op_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: forwarding, hazard stalls, backpressure,
// scoreboard set/clear races and asynchronous reset.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [7:0]  in_op;
    logic [4:0]  rf_rnum1;
    logic [4:0]  rf_rnum2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [7:0]  out_op;
    logic [15:0] stall_cnt;

    int total;
    int bad;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_rd_we  (in_rd_we),
        .in_op     (in_op),
        .rf_rnum1  (rf_rnum1),
        .rf_rnum2  (rf_rnum2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we),
        .out_op    (out_op),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic we, input logic [7:0] op,
                                 input logic [31:0] d1, input logic [31:0] d2);
        in_valid  = v;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_rd_we  = we;
        in_op     = op;
        rf_rdata1 = d1;
        rf_rdata2 = d2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst       = 1'b0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00, 32'h0, 32'h0);

        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_a", out_a, 32'd0);
        checkOutput("rst_out_op", 32'(out_op), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        $display("[TB] basic issue rs1=1 rs2=2 rd=3");
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 8'h5A, 32'h11, 32'h22);
        checkOutput("issue_in_ready", 32'(in_ready), 32'd1);
        checkOutput("issue_rnum1", 32'(rf_rnum1), 32'd1);
        checkOutput("issue_rnum2", 32'(rf_rnum2), 32'd2);
        tick();
        checkOutput("issue_out_valid", 32'(out_valid), 32'd1);
        checkOutput("issue_out_a", out_a, 32'h11);
        checkOutput("issue_out_b", out_b, 32'h22);
        checkOutput("issue_out_rd", 32'(out_rd), 32'd3);
        checkOutput("issue_out_rd_we", 32'(out_rd_we), 32'd1);
        checkOutput("issue_out_op", 32'(out_op), 32'h5A);

        $display("[TB] RAW stall on r3 then forward");
        applyStimulus(1'b1, 5'd3, 5'd1, 5'd0, 1'b0, 8'h01, 32'h33, 32'h77);
        checkOutput("raw_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("raw_drain_valid", 32'(out_valid), 32'd0);
        checkOutput("raw_stall_1", 32'(stall_cnt), 32'd1);
        tick();
        checkOutput("raw_stall_2", 32'(stall_cnt), 32'd2);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        wb_data  = 32'hABCD;
        #1;
        checkOutput("fwd_in_ready", 32'(in_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        checkOutput("fwd_out_a", out_a, 32'hABCD);
        checkOutput("fwd_out_b", out_b, 32'h77);
        checkOutput("fwd_stall_hold", 32'(stall_cnt), 32'd2);

        $display("[TB] zero register and address aliasing");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 8'h02, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("zero_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("zero_out_a", out_a, 32'd0);
        checkOutput("zero_out_b", out_b, 32'd0);
        checkOutput("zero_out_rd_we", 32'(out_rd_we), 32'd1);
        applyStimulus(1'b1, 5'd4, 5'd7, 5'd4, 1'b1, 8'h03, 32'hFFFFFFFF, 32'h99);
        checkOutput("alias_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("alias_out_a", out_a, 32'd0);
        checkOutput("alias_out_b", out_b, 32'h99);
        checkOutput("alias_out_rd", 32'(out_rd), 32'd4);

        $display("[TB] backpressure for three cycles");
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd2, 1'b1, 8'h33, 32'h10, 32'h20);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_out_b", out_b, 32'h99);
            checkOutput("bp_out_op", 32'(out_op), 32'h03);
        end
        checkOutput("bp_no_stall_count", 32'(stall_cnt), 32'd2);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("b2b1_out_a", out_a, 32'h10);
        checkOutput("b2b1_out_b", out_b, 32'h20);
        checkOutput("b2b1_out_op", 32'(out_op), 32'h33);
        applyStimulus(1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 8'h44, 32'h44, 32'h44);
        checkOutput("b2b2_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("b2b2_out_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b2_out_a", out_a, 32'h44);
        checkOutput("b2b2_out_rd", 32'(out_rd), 32'd1);

        $display("[TB] retire r1 and r2, then set/clear race on r2");
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00, 32'h0, 32'h0);
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 32'h1111;
        tick();
        wb_rd    = 5'd2;
        wb_data  = 32'h2222;
        tick();
        wb_valid = 1'b0;
        applyStimulus(1'b1, 5'd2, 5'd1, 5'd0, 1'b0, 8'h05, 32'h1, 32'h2);
        checkOutput("clr_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("clr_out_a", out_a, 32'h1);
        checkOutput("clr_out_b", out_b, 32'h2);
        wb_valid = 1'b1;
        wb_rd    = 5'd2;
        wb_data  = 32'h5555;
        applyStimulus(1'b1, 5'd2, 5'd0, 5'd2, 1'b1, 8'h06, 32'h66, 32'h0);
        checkOutput("race_in_ready", 32'(in_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        checkOutput("race_out_a", out_a, 32'h5555);
        applyStimulus(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 8'h07, 32'h66, 32'h0);
        checkOutput("race_pending_r2", 32'(in_ready), 32'd0);

        $display("[TB] asynchronous reset during a stall");
        out_ready = 1'b0;
        #1;
        tick();
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        checkOutput("pre_rst_stall", 32'(stall_cnt), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_stall", 32'(stall_cnt), 32'd0);
        checkOutput("async_rst_out_a", out_a, 32'd0);
        checkOutput("async_rst_out_rd", 32'(out_rd), 32'd0);
        checkOutput("async_rst_pending", 32'(in_ready), 32'd1);
        #10;
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
